// File: rtl/fft_pkg.sv
// Shared FFT constants and types used by the twiddle index path.
package fft_pkg;

    localparam int unsigned LOG2N = 8;
    localparam int unsigned TW_W  = LOG2N - 1;

    typedef logic [TW_W-1:0] tw_index_t;
    typedef logic [2:0]      stage_t;

endpackage

// File: rtl/twiddle_k_counter.sv
// Butterfly-group counter k for the current stage. It wraps to 0 once it
// reaches 2^stage-1, or immediately when the stage is out of range.
module twiddle_k_counter
    import fft_pkg::stage_t;
#(
    parameter int unsigned LOG2N = fft_pkg::LOG2N,
    parameter int unsigned TW_W  = fft_pkg::TW_W
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            enable,
    input  logic            clear,
    input  logic [2:0]      stage,
    output logic [TW_W-1:0] k
);

    stage_t          w_stage;
    logic            w_in_range;
    logic [TW_W:0]   w_limit;
    logic            w_wrap;
    logic [TW_W-1:0] r_k;

    // Wrap detection. The >= compare also catches a k left above the limit
    // by a stage change without a clear.
    always_comb begin
        w_stage    = stage;
        w_in_range = 32'(w_stage) < LOG2N;
        w_limit    = ((TW_W+1)'(1) << w_stage) - (TW_W+1)'(1);
        w_wrap     = !w_in_range || ({1'b0, r_k} >= w_limit);
    end

    // k register: clear wins over enable, and enable wraps at the limit.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_k <= '0;
        end else if (clear) begin
            r_k <= '0;
        end else if (enable) begin
            r_k <= w_wrap ? '0 : r_k + TW_W'(1);
        end
    end

    assign k = r_k;

endmodule

// File: rtl/twiddle_index_2.sv
// Twiddle ROM address generator: index = k << (LOG2N-1-stage). The address
// is forced to 0 when the stage is out of range.
module twiddle_index_2 #(
    parameter int unsigned LOG2N = fft_pkg::LOG2N,
    parameter int unsigned TW_W  = fft_pkg::TW_W
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [2:0]      stage_count_out,
    input  logic            k_enable,
    input  logic            k_clear,
    output logic [TW_W-1:0] index_val
);

    logic [TW_W-1:0] w_k;
    logic            w_in_range;
    logic [31:0]     w_shamt;

    twiddle_k_counter #(
        .LOG2N (LOG2N),
        .TW_W  (TW_W)
    ) u_k_counter (
        .clk    (clk),
        .nrst   (nrst),
        .enable (k_enable),
        .clear  (k_clear),
        .stage  (stage_count_out),
        .k      (w_k)
    );

    // Combinational shift of k by the current stage, with the out-of-range guard.
    always_comb begin
        w_in_range = 32'(stage_count_out) < LOG2N;
        w_shamt    = LOG2N - 32'd1 - 32'(stage_count_out);
        index_val  = w_in_range ? (w_k << w_shamt) : '0;
    end

endmodule

// File: tb/tb_twiddle_index_2.sv
// Scoreboard bench for twiddle_index_2: a reference k model pushes the
// expected index when stimulus is driven, and the value is popped and
// compared once the DUT output has settled.
module tb_twiddle_index_2;

    localparam int unsigned LOG2N = 8;
    localparam int unsigned TW_W  = 7;

    logic            clk;
    logic            nrst;
    logic [2:0]      stage_count_out;
    logic            k_enable;
    logic            k_clear;
    logic [TW_W-1:0] index_val;

    int unsigned     n_vec;
    int unsigned     n_err;
    int unsigned     model_k;
    logic [TW_W-1:0] exp_q[$];

    twiddle_index_2 #(
        .LOG2N (LOG2N),
        .TW_W  (TW_W)
    ) dut (
        .clk             (clk),
        .nrst            (nrst),
        .stage_count_out (stage_count_out),
        .k_enable        (k_enable),
        .k_clear         (k_clear),
        .index_val       (index_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [TW_W-1:0] model_idx();
        int unsigned s;
        s = int'(stage_count_out);
        if (s >= LOG2N) return '0;
        return TW_W'(model_k << (LOG2N - 1 - s));
    endfunction

    task automatic check(input string tag, input logic [TW_W-1:0] got, input logic [TW_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: index_val=%0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_now(input string tag);
        exp_q.push_back(model_idx());
        check(tag, index_val, exp_q.pop_front());
    endtask

    // One clock edge with the given controls; the model advances alongside.
    task automatic cycle(input string tag, input logic en, input logic clr);
        int unsigned lim;
        k_enable = en;
        k_clear  = clr;
        lim = (int'(stage_count_out) >= LOG2N) ? 0 : (32'd1 << stage_count_out) - 1;
        if (clr)               model_k = 0;
        else if (en)           model_k = (model_k >= lim) ? 0 : model_k + 1;
        exp_q.push_back(model_idx());
        @(posedge clk);
        #1;
        k_enable = 1'b0;
        k_clear  = 1'b0;
        check(tag, index_val, exp_q.pop_front());
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_k = 0;
        nrst = 1'b0;
        stage_count_out = 3'd3;
        k_enable = 1'b0;
        k_clear  = 1'b0;

        // Reset held two cycles, then released with no enables
        repeat (2) @(posedge clk);
        #1;
        expect_now("reset");
        nrst = 1'b1;
        cycle("post_reset_idle0", 1'b0, 1'b0);
        cycle("post_reset_idle1", 1'b0, 1'b0);

        // Stage 0: every enable wraps immediately
        stage_count_out = 3'd0;
        cycle("s0_clear", 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle("s0_enable", 1'b1, 1'b0);

        // Stage 1: clear wins over enable, then 64 and wrap
        stage_count_out = 3'd1;
        cycle("s1_clear_and_enable", 1'b1, 1'b1);
        cycle("s1_enable_64", 1'b1, 1'b0);
        check("s1_literal_64", index_val, 7'd64);
        cycle("s1_wrap", 1'b1, 1'b0);

        // Stage 2: enables separated by idle cycles
        stage_count_out = 3'd2;
        cycle("s2_clear", 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle("s2_enable", 1'b1, 1'b0);
            cycle("s2_hold", 1'b0, 1'b0);
        end

        // Stage 7: full count, wrap, then asynchronous reset mid-count
        stage_count_out = 3'd7;
        cycle("s7_clear", 1'b0, 1'b1);
        for (int i = 0; i < 127; i++) cycle("s7_count", 1'b1, 1'b0);
        check("s7_literal_127", index_val, 7'd127);
        cycle("s7_wrap", 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle("s7_recount", 1'b1, 1'b0);
        nrst = 1'b0;
        #2;
        model_k = 0;
        expect_now("s7_async_reset");
        nrst = 1'b1;
        cycle("s7_after_reset_enable", 1'b1, 1'b0);

        // Stage 3 with k=5, stage change to 7 without clear, then clear
        stage_count_out = 3'd3;
        cycle("s3_clear", 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle("s3_count", 1'b1, 1'b0);
        check("s3_literal_80", index_val, 7'd80);
        stage_count_out = 3'd7;
        #1;
        expect_now("stage_change_comb");
        cycle("s7_clear_again", 1'b0, 1'b1);

        // k above the new stage's limit wraps on the next enable
        for (int i = 0; i < 5; i++) cycle("s7_to5", 1'b1, 1'b0);
        stage_count_out = 3'd2;
        #1;
        expect_now("s2_oversize_k");
        cycle("s2_oversize_wrap", 1'b1, 1'b0);
        cycle("s2_after_wrap", 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
